// File: rtl/divider_core.sv
// Sequential restoring divider: one quotient bit per clock, WIDTH steps per
// division, with a single-cycle divide-by-zero shortcut. Results are held in
// dedicated output registers so CALC-phase values never reach the ports.
module divider_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start_in,
  input  logic [WIDTH-1:0] Dvdn_in,
  input  logic [WIDTH-1:0] Dvsr_in,
  output logic             Ready_out,
  output logic             Done_out,
  output logic [WIDTH-1:0] Quot_out,
  output logic [WIDTH-1:0] Rem_out,
  output logic             Dz_out
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q,   cnt_d;
  logic [2*WIDTH-1:0] r_q,     r_d;
  logic [WIDTH-1:0]   dvsr_q,  dvsr_d;
  logic [WIDTH-1:0]   quot_q,  quot_d;
  logic [WIDTH-1:0]   rem_q,   rem_d;
  logic               dz_q,    dz_d;

  // Restoring-step datapath: the upper half plus the bit shifted out of it
  // forms a WIDTH+1-bit partial remainder that is compared with the divisor.
  // The difference always fits in WIDTH bits when the compare succeeds.
  logic [WIDTH:0]       partial;
  logic                 ge;
  logic [WIDTH-1:0]     sub;
  logic [2*WIDTH-1:0]   r_step;

  // One restoring step computed from the current remainder register
  always_comb begin
    partial = r_q[2*WIDTH-1:WIDTH-1];
    ge      = (partial >= {1'b0, dvsr_q});
    sub     = partial[WIDTH-1:0] - dvsr_q;
    if (ge) begin
      r_step = {sub, r_q[WIDTH-2:0], 1'b1};
    end else begin
      r_step = {r_q[2*WIDTH-2:0], 1'b0};
    end
  end

  // Next-state logic for the IDLE/CALC/DONE controller and its registers
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    dvsr_d  = dvsr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (Start_in) begin
          dvsr_d  = Dvsr_in;
          r_d     = {{WIDTH{1'b0}}, Dvdn_in};
          cnt_d   = '0;
          dz_d    = 1'b0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (dvsr_q == '0) begin
          // zero divisor: skip the iterations, R still holds the dividend
          quot_d  = '1;
          rem_d   = r_q[WIDTH-1:0];
          dz_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          r_d   = r_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            quot_d  = r_step[WIDTH-1:0];
            rem_d   = r_step[2*WIDTH-1:WIDTH];
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      dvsr_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      dvsr_q  <= dvsr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign Ready_out = (state_q == ST_IDLE);
  assign Done_out  = (state_q == ST_DONE);
  assign Quot_out  = quot_q;
  assign Rem_out   = rem_q;
  assign Dz_out    = dz_q;

endmodule

// File: tb/tb_divider_core.sv
// Randomized self-checking bench for divider_core against an arithmetic
// reference (native / and %), plus directed corner and reset scenarios.
module tb_divider_core;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dvdn;
  logic [W-1:0] dvsr;
  logic         ready;
  logic         done;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
  logic         dz;

  int n_checks;
  int n_fail;

  divider_core #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Start_in  (start),
    .Dvdn_in   (dvdn),
    .Dvsr_in   (dvsr),
    .Ready_out (ready),
    .Done_out  (done),
    .Quot_out  (quot),
    .Rem_out   (rem),
    .Dz_out    (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Run one division starting at a point between edges with the block idle.
  // When disturb is set, a second Start with new operands is pulsed during
  // CALC and must be ignored. Returns at a negedge.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit disturb);
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;
    logic [63:0]  recon;
    int           lat;
    int           extra;
    bit           seen;

    if (b == '0) begin
      exp_q = '1;
      exp_r = a;
    end else begin
      exp_q = a / b;
      exp_r = a % b;
    end

    check_eq("ready_before", 64'(ready), 64'd1);
    start = 1'b1;
    dvdn  = a;
    dvsr  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    dvdn  = $urandom;
    dvsr  = $urandom;

    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < int'(W) + 8) begin
      @(posedge clk);
      lat++;
      #1;
      if (disturb) begin
        start = (lat == 10);
        if (lat == 10) begin
          dvdn = 32'd50;
          dvsr = 32'd3;
        end
      end
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    start = 1'b0;

    if (!seen) begin
      check_eq("done_timeout", 64'd0, 64'd1);
    end else begin
      check_eq("latency", 64'(lat), (b == '0) ? 64'd1 : 64'(W));
      check_eq("quot", 64'(quot), 64'(exp_q));
      check_eq("rem", 64'(rem), 64'(exp_r));
      check_eq("dz", 64'(dz), (b == '0) ? 64'd1 : 64'd0);
      if (b != '0) begin
        recon = 64'(quot) * 64'(b) + 64'(rem);
        check_eq("invariant", recon, 64'(a));
        check_eq("rem_lt_dvsr", 64'(rem < b), 64'd1);
      end
      @(negedge clk);
      check_eq("done_one_cycle", 64'(done), 64'd0);
      check_eq("ready_after", 64'(ready), 64'd1);
      check_eq("quot_hold", 64'(quot), 64'(exp_q));
      if (disturb) begin
        extra = 0;
        for (int i = 0; i < int'(W) + 4; i++) begin
          @(negedge clk);
          if (done) extra++;
        end
        check_eq("single_done", 64'(extra), 64'd0);
        check_eq("quot_hold_long", 64'(quot), 64'(exp_q));
      end
    end
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           sel;
    int           extra;

    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dvdn     = '0;
    dvsr     = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", 64'(ready), 64'd1);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_quot", 64'(quot), 64'd0);
    check_eq("rst_rem", 64'(rem), 64'd0);
    check_eq("rst_dz", 64'(dz), 64'd0);
    rst_n = 1'b1;

    // first start accepted on the first edge after release
    run_div(32'd100, 32'd7, 1'b0);
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0);
    run_div(32'd3, 32'd10, 1'b0);
    run_div(32'd5, 32'd0, 1'b0);
    run_div(32'd100, 32'd7, 1'b0);
    run_div(32'd100, 32'd7, 1'b1);

    // reset in the middle of CALC aborts the division
    start = 1'b1;
    dvdn  = 32'd100;
    dvsr  = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("abort_ready", 64'(ready), 64'd1);
    check_eq("abort_done", 64'(done), 64'd0);
    check_eq("abort_quot", 64'(quot), 64'd0);
    check_eq("abort_rem", 64'(rem), 64'd0);
    check_eq("abort_dz", 64'(dz), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < int'(W) + 4; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check_eq("abort_no_done", 64'(extra), 64'd0);
    run_div(32'd9, 32'd4, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      sel = $urandom_range(0, 7);
      a   = $urandom;
      b   = $urandom;
      case (sel)
        0: b = 32'd1;
        1: b = 32'hFFFF_FFFF;
        2: begin
          if (b == '0) b = 32'd1;
          a = a % b;
        end
        3: b = 32'($urandom_range(0, 15));
        4: a = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_div(a, b, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/divider_core.md
DIVIDER_CORE -- requirements
Module: divider_core

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, setting operand and result width in bits.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 The block SHALL have port Start_in  input  1  request to begin a division.
REQ-005 The block SHALL have port Dvdn_in  input  WIDTH  unsigned dividend.
REQ-006 The block SHALL have port Dvsr_in  input  WIDTH  unsigned divisor, driven by the Divisor register stage output.
REQ-007 The block SHALL have port Ready_out  output  1  high when a new Start_in will be accepted.
REQ-008 The block SHALL have port Done_out  output  1  one-cycle pulse marking valid results.
REQ-009 The block SHALL have port Quot_out  output  WIDTH  quotient.
REQ-010 The block SHALL have port Rem_out  output  WIDTH  remainder.
REQ-011 The block SHALL have port Dz_out  output  1  divide-by-zero flag for the last accepted division.

Function
REQ-012 The block SHALL implement FSM states IDLE, CALC, DONE; Ready_out = 1 only in IDLE.
REQ-013 In IDLE, Start_in = 1 at rising edge N SHALL latch Dvsr_in, load internal 2*WIDTH remainder register R = {0, Dvdn_in}, clear iteration counter, clear Dz_out, and enter CALC.
REQ-014 Start_in while not in IDLE SHALL be ignored; no queueing, no effect on the running division.
REQ-015 Changes on Dvdn_in/Dvsr_in after edge N SHALL NOT affect the running division.
REQ-016 Each CALC edge SHALL perform one restoring step: shift R left 1; if R upper half >= latched divisor (WIDTH+1-bit unsigned compare), upper half -= divisor and R[0] = 1, else R[0] = 0.
REQ-017 CALC SHALL perform exactly WIDTH steps, on edges N+1 through N+WIDTH, then enter DONE.
REQ-018 In DONE, Done_out SHALL be 1 for exactly one cycle, Quot_out = R lower half, Rem_out = R upper half; next edge returns to IDLE.
REQ-019 Quot_out, Rem_out, Dz_out SHALL hold their values from DONE until the next accepted Start_in, and SHALL NOT show intermediate CALC values.
REQ-020 If latched divisor = 0 at edge N, the block SHALL skip CALC, enter DONE at edge N+1 with Quot_out = all ones, Rem_out = dividend, Dz_out = 1.
REQ-021 Arithmetic SHALL be unsigned; invariant dividend = Quot_out*divisor + Rem_out with Rem_out < divisor for nonzero divisor.
REQ-022 Latency from accepting edge to Done_out high SHALL be WIDTH edges (1 edge for divide-by-zero); throughput one division per WIDTH+2 cycles.

Reset
REQ-023 rst_n = 0 SHALL immediately force IDLE, Ready_out = 1, Done_out = 0, Quot_out = 0, Rem_out = 0, Dz_out = 0, counter and R to 0.
REQ-024 Reset asserted mid-CALC SHALL abort the division; no Done_out pulse for it after release.
REQ-025 First Start_in SHALL be accepted on the first rising edge with rst_n = 1.

Verification
REQ-026 Dvdn 100, Dvsr 7, Start 1 cycle -> Done_out after 32 edges, Quot 0x0000000E, Rem 0x00000002, Dz 0.
REQ-027 Dvdn 0xFFFFFFFF, Dvsr 1 -> Quot 0xFFFFFFFF, Rem 0; Dvdn 3, Dvsr 10 -> Quot 0, Rem 3.
REQ-028 Dvdn 5, Dvsr 0 -> Done_out one edge after accept, Quot 0xFFFFFFFF, Rem 5, Dz 1; next normal division clears Dz.
REQ-029 Start 100/7, then Start 50/5 pulsed at CALC step 10 and Dvsr_in changed to 3 -> result still Quot 14, Rem 2; only one Done_out pulse.
REQ-030 Start 100/7, rst_n low at CALC step 10 -> all outputs 0, Ready_out 1 at once, no Done_out; then 9/4 -> Quot 2, Rem 1.
REQ-031 Random bench: 1000 random unsigned pairs incl. divisor 1, 0xFFFFFFFF, dividend < divisor -> REQ-021 invariant holds every Done_out.
